// File: rtl/activation_pipe.sv
// Two-stage handshaked activation unit: per-beat sigmoid / ReLU / identity over LANES lanes,
// plus a saturating count of saturated sigmoid beats for quantisation debug.
module activation_pipe #(
  parameter int DATA_W  = 8,
  parameter int FRAC_IN = 4,
  parameter int LANES   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic [LANES*DATA_W-1:0] in_zed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_act,
  input  logic                    clear_count,
  output logic [CNT_W-1:0]        sat_count,
  output logic                    busy
);

  typedef enum logic [1:0] {
    MODE_SIGMOID = 2'b00,
    MODE_RELU    = 2'b01,
    MODE_IDENT   = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam int ROM_DEPTH = 2**DATA_W;

  // Sigmoid table is evaluated at elaboration from its defining formula, so no init file is needed.
  logic [DATA_W-1:0] sig_rom [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    localparam int  SZ  = (g >= ROM_DEPTH / 2) ? g - ROM_DEPTH : g;
    localparam real SV  = real'(SZ) / real'(2**FRAC_IN);
    localparam real RAW = real'(ROM_DEPTH) / (1.0 + $exp(-SV));
    localparam int  RND = $rtoi(RAW + 0.5);
    localparam int  CLP = (RND > ROM_DEPTH - 1) ? ROM_DEPTH - 1 : RND;
    assign sig_rom[g] = DATA_W'(CLP);
  end

  logic                    s1_v_q;
  mode_e                   s1_mode_q;
  logic [LANES*DATA_W-1:0] s1_zed_q;
  logic                    s2_v_q;
  logic                    s2_sig_q;
  logic [LANES*DATA_W-1:0] s2_act_q;
  logic [LANES*DATA_W-1:0] s2_act_d;
  logic [CNT_W-1:0]        sat_count_q;
  logic [CNT_W-1:0]        sat_count_d;
  logic                    en1;
  logic                    en2;
  logic                    out_hs;
  logic                    s2_sat;

  assign en2    = !s2_v_q || out_ready;
  assign en1    = !s1_v_q || en2;
  assign out_hs = s2_v_q && out_ready;

  always_comb begin
    // NOTE: default assignment first, so no path leaves s2_act_d unassigned and no latch is inferred.
    s2_act_d = '0;
    for (int i = 0; i < LANES; i++) begin
      case (s1_mode_q)
        MODE_SIGMOID: s2_act_d[i*DATA_W +: DATA_W] = sig_rom[s1_zed_q[i*DATA_W +: DATA_W]];
        MODE_RELU:    s2_act_d[i*DATA_W +: DATA_W] = s1_zed_q[i*DATA_W + DATA_W - 1]
                                                     ? {DATA_W{1'b0}}
                                                     : s1_zed_q[i*DATA_W +: DATA_W];
        default:      s2_act_d[i*DATA_W +: DATA_W] = s1_zed_q[i*DATA_W +: DATA_W];
      endcase
    end
  end

  // A sigmoid beat saturates when any lane sits on either rail of the output range.
  always_comb begin
    s2_sat = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (s2_act_q[i*DATA_W +: DATA_W] == {DATA_W{1'b0}} ||
          s2_act_q[i*DATA_W +: DATA_W] == {DATA_W{1'b1}}) begin
        s2_sat = 1'b1;
      end
    end
    s2_sat = s2_sat && s2_sig_q;
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (clear_count) begin
      sat_count_d = '0;
    end else if (out_hs && s2_sat && sat_count_q != {CNT_W{1'b1}}) begin
      sat_count_d = sat_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_sig_q    <= 1'b0;
      s2_act_q    <= '0;
      sat_count_q <= '0;
    end else begin
      // NOTE: non-blocking, so both stages shift from pre-edge values and a full pipe moves without a bubble.
      if (en1) s1_v_q <= in_valid;
      if (en2) s2_v_q <= s1_v_q;
      if (en2 && s1_v_q) begin
        s2_act_q <= s2_act_d;
        s2_sig_q <= (s1_mode_q == MODE_SIGMOID);
      end
      sat_count_q <= sat_count_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the S1 payload carries no reset; s1_v_q alone decides whether it means anything.
    if (en1 && in_valid) begin
      s1_zed_q  <= in_zed;
      s1_mode_q <= mode_e'(in_mode);
    end
  end

  assign in_ready  = en1;
  assign out_valid = s2_v_q;
  assign out_act   = s2_act_q;
  assign sat_count = sat_count_q;
  assign busy      = s1_v_q || s2_v_q;

endmodule
